// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the sync FIFO writer/reader controller pair:
// state encodings, default thresholds and the fill pattern.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      WR_WRITING       = 2'd0,
      WR_WAIT_TO_STOP  = 2'd1,
      WR_STOPPED       = 2'd2,
      WR_WAIT_TO_START = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE         = 2'd0,
      RD_READING      = 2'd1,
      RD_WAIT_TO_STOP = 2'd2
   } rd_state_t;

   localparam int          DEF_START_LEVEL = 4;
   localparam int          DEF_STOP_LEVEL  = 1;
   localparam logic [7:0]  PATTERN_AA      = 8'hAA;

   // Pointer advance for the 3-entry output buffer (0 -> 1 -> 2 -> 0).
   function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus valid/ready output stream of the FIFO reader.
// master = the reader, slave = FIFO model / consumer side.
interface fifo_reader_if #(
   parameter int DATA_W  = 8,
   parameter int WORDS_W = 4
) ();
   logic               rd_en;
   logic [DATA_W-1:0]  fifo_rd_data;
   logic [WORDS_W-1:0] fifo_words;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               out_ready;

   modport master (
      output rd_en, out_valid, out_data,
      input  fifo_rd_data, fifo_words, out_ready
   );

   modport slave (
      input  rd_en, out_valid, out_data,
      output fifo_rd_data, fifo_words, out_ready
   );
endinterface

// File: rtl/fifo_reader_out_skid_buf.sv
// out_skid_buf: 3-entry valid/ready buffer. Push and pop in the same cycle
// are both honoured; the head word is shown on o_data (0 when empty).
module out_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ready,
   output logic [1:0]        o_buf_count
);
   import fifo_ctrl_pkg::*;

   logic [DATA_W-1:0] r_mem [0:2];
   logic [1:0]        r_head;
   logic [1:0]        r_tail;
   logic [1:0]        r_count;
   logic              w_pop;

   assign w_pop       = o_valid && i_ready;
   assign o_valid     = (r_count != 2'd0);
   assign o_data      = o_valid ? r_mem[r_head] : '0;
   assign o_buf_count = r_count;

   // Storage array; contents need no reset because o_data is gated by count.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_tail] <= i_push_data;
   end

   // Pointers and occupancy; reset drops any buffered words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= 2'd0;
         r_tail  <= 2'd0;
         r_count <= 2'd0;
      end else begin
         if (i_push) r_tail <= buf_ptr_inc(r_tail);
         if (w_pop)  r_head <= buf_ptr_inc(r_head);
         unique case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller of the shared sync FIFO. Waits until the
// FIFO holds START_LEVEL words, then drains back-to-back down to STOP_LEVEL,
// passing words through a 3-entry buffer to a valid/ready consumer.
// Optional build macro FIFO_READER_READ_CHECK_EN adds a compare of every
// buffered word against EXPECTED and the saturating o_err_count port.
//
// state            | meaning
// RD_IDLE          | waiting for fifo_words >= START_LEVEL
// RD_READING       | issuing reads while buffer space and FIFO level allow
// RD_WAIT_TO_STOP  | one quiet cycle so the final read lands, then idle
module fifo_reader
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int WORDS_W     = 4,
   parameter int START_LEVEL = DEF_START_LEVEL,
   parameter int STOP_LEVEL  = DEF_STOP_LEVEL
`ifdef FIFO_READER_READ_CHECK_EN
   ,
   parameter logic [DATA_W-1:0] EXPECTED = DATA_W'(PATTERN_AA)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_reader_if.master     bus,
   output logic [15:0]       o_rd_count
`ifdef FIFO_READER_READ_CHECK_EN
   ,
   output logic [7:0]        o_err_count
`endif
);

   if (!(STOP_LEVEL >= 0 && STOP_LEVEL < START_LEVEL &&
         START_LEVEL <= (2 ** WORDS_W) - 1)) begin : g_param_err
      $error("fifo_reader: need 0 <= STOP_LEVEL < START_LEVEL <= 2**WORDS_W-1");
   end

   localparam logic [WORDS_W:0] C_START = (WORDS_W+1)'(START_LEVEL);
   localparam logic [WORDS_W:0] C_STOP  = (WORDS_W+1)'(STOP_LEVEL);
   localparam logic [WORDS_W:0] C_STOP1 = (WORDS_W+1)'(STOP_LEVEL + 1);

   rd_state_t          r_state;
   logic               r_rd_pending;
   logic [15:0]        r_rd_count;
   logic [WORDS_W:0]   w_words;
   logic [1:0]         w_buf_count;
   logic               w_space_ok;
   logic               w_above_stop;
   logic               w_rd_en;
   logic               w_pop;

   // Space check uses registered occupancy only, so out_ready never reaches rd_en.
   assign w_words      = {1'b0, bus.fifo_words};
   assign w_space_ok   = ({1'b0, w_buf_count} + {2'b00, r_rd_pending}) <= 3'd2;
   assign w_above_stop = (w_words > C_STOP);
   assign w_rd_en      = (r_state == RD_READING) && w_space_ok && w_above_stop;
   assign bus.rd_en    = w_rd_en;
   assign w_pop        = bus.out_valid && bus.out_ready;
   assign o_rd_count   = r_rd_count;

   // Burst control: hysteresis between START_LEVEL and STOP_LEVEL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RD_IDLE;
      end else begin
         case (r_state)
            RD_IDLE:
               if (w_words >= C_START) r_state <= RD_READING;
            RD_READING:
               if (!w_above_stop || (w_rd_en && (w_words <= C_STOP1)))
                  r_state <= RD_WAIT_TO_STOP;
            RD_WAIT_TO_STOP:
               r_state <= RD_IDLE;
            default:
               r_state <= RD_IDLE;
         endcase
      end
   end

   // Read data returns one cycle after the strobe; track the in-flight read.
   always_ff @(posedge clk) begin
      if (!rst_n) r_rd_pending <= 1'b0;
      else        r_rd_pending <= w_rd_en;
   end

   // Delivered-word counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n)     r_rd_count <= 16'd0;
      else if (w_pop) r_rd_count <= r_rd_count + 16'd1;
   end

   out_skid_buf #(.DATA_W(DATA_W)) u_out_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_rd_pending),
      .i_push_data (bus.fifo_rd_data),
      .o_valid     (bus.out_valid),
      .o_data      (bus.out_data),
      .i_ready     (bus.out_ready),
      .o_buf_count (w_buf_count)
   );

`ifdef FIFO_READER_READ_CHECK_EN
   logic [7:0] r_err_count;
   assign o_err_count = r_err_count;

   // Count words entering the buffer that differ from the reference, saturating.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err_count <= 8'd0;
      else if (r_rd_pending && (bus.fifo_rd_data != EXPECTED) && (r_err_count != 8'hFF))
         r_err_count <= r_err_count + 8'd1;
   end
`endif

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side controller for the shared 8-bit sync FIFO; consumer end of the writer FSM that fills it with 8'hAA.
- Hysteresis drain: idle until FIFO holds START_LEVEL words, then read back-to-back until it falls to STOP_LEVEL.
- Fetched words pass through a 3-entry output buffer to a valid/ready consumer.
- Counts delivered words.

Parameters:
- DATA_W, 8, FIFO/output data width
- WORDS_W, 4, width of fifo_words
- START_LEVEL, 4, fifo_words threshold (>=) that starts a read burst
- STOP_LEVEL, 1, burst stops once fifo_words would fall to this level; never read below it
- EXPECTED, 8'hAA, reference value for the optional data check

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rd_en  out  1  FIFO read strobe, combinational from state/registers
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after rd_en (1-cycle latency)
- fifo_words  in  WORDS_W  FIFO occupancy; already reflects reads/writes of the previous edge
- out_valid  out  1  output word available
- out_data  out  DATA_W  output word (head of buffer)
- out_ready  in  1  consumer accepts when out_valid && out_ready
- rd_count  out  16  words delivered to consumer, wraps 16'hFFFF->0
- err_count  out  8  (READ_CHECK_EN only) mismatch count, saturating at 8'hFF

Behaviour:
- Reset (edge with rst_n=0): state IDLE, rd_pending 0, buffer emptied (contents dropped), rd_count 0, err_count 0. rd_en=0, out_valid=0, out_data=0. Mid-burst reset discards in-flight reads; the FIFO is not rewound.
- States: IDLE=0, READING=1, WAIT_TO_STOP=2; unused encoding goes to IDLE.
- IDLE: rd_en=0; fifo_words>=START_LEVEL -> READING next edge.
- READING: rd_en = space_ok && (fifo_words > STOP_LEVEL).
  - If fifo_words <= STOP_LEVEL+1 and the rd_en condition holds, this is the last read -> WAIT_TO_STOP.
  - If fifo_words <= STOP_LEVEL (writer stalled) -> WAIT_TO_STOP, no read.
  - Otherwise stay.
- WAIT_TO_STOP: rd_en=0 for exactly one cycle so the last read lands -> IDLE.
- space_ok = (buf_count + rd_pending) <= 2, registered values only, no out_ready path into rd_en. Guarantees no overflow; sustains 1 word/cycle with out_ready held high.
- rd_pending <= rd_en. When rd_pending=1, fifo_rd_data is pushed into the buffer that edge.
- Buffer: 3-entry FIFO. Push and pop in the same cycle are both honoured. out_data is the head, held stable while out_valid && !out_ready.
- rd_count increments on each accepted handshake.
- Simultaneous writer activity: the decision uses the current fifo_words only. Extra words arriving during a burst extend it.
- rd_en is never asserted when fifo_words==0, for any parameter choice.
- Required: STOP_LEVEL < START_LEVEL <= 2^WORDS_W-1. Violations are a parameter error, caught by an elaboration check.

Optional Feature:
- Macro FIFO_READER_READ_CHECK_EN.
- Defined:
  - Each word pushed into the buffer is compared with EXPECTED.
  - A mismatch increments err_count (saturating) on the push edge.
  - err_count port is present.
- Undefined: no compare logic; err_count port is absent.

Decomposition:
- Shared package fifo_ctrl_pkg holds:
  - state encodings for writer and reader (WRITING/WAIT_TO_STOP/STOPPED/WAIT_TO_START; IDLE/READING/WAIT_TO_STOP)
  - default thresholds and the 8'hAA pattern constant
- One sub-module: out_skid_buf, a 3-entry valid/ready buffer with a buf_count output.

Test Plan:
- fifo_words=3 held -> rd_en stays 0, state IDLE; step to 4 -> rd_en=1 on that cycle's state READING (one cycle later).
- Model FIFO preloaded with 6 words of 8'hAA, no writes, out_ready=1 -> exactly 5 rd_en pulses back-to-back, fifo_words ends at 1, 5 handshakes with out_data=8'hAA, rd_count=5, state back to IDLE.
- As above with out_ready=0 -> exactly 3 reads issued, out_valid=1 holding 8'hAA. Raise out_ready -> remaining 2 reads complete, never more than 3 buffered.
- Writer adds 1 word/cycle during a burst from 4 words -> burst continues until writer stops and fifo_words reaches 1; no read at fifo_words<=1.
- rst_n=0 for one edge mid-burst with 2 words buffered -> next cycle out_valid=0, rd_en=0, rd_count=0, state IDLE.
- With FIFO_READER_READ_CHECK_EN: inject 8'h55 twice among 8'hAA -> err_count=2; with 300 mismatches -> err_count=8'hFF.
